// File: rtl/regbank_n.sv
// Parametrised register bank: NREG x WIDTH registers sharing one FunSel operation,
// two combinational read ports and per-register sticky wrap/saturate flags.
module regbank_n #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  parameter int SAT   = 0,
  localparam int SW   = ($clog2(NREG) > 1) ? $clog2(NREG) : 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  input  logic [NREG-1:0]  RSel,
  input  logic [SW-1:0]    OutASel,
  input  logic [SW-1:0]    OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic [NREG-1:0]  Wrap
);

  localparam int HALF = WIDTH / 2;
  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [NREG-1:0]  wrap_q;
  logic [NREG-1:0]  wrap_d;

  // Each selected register applies the op to its own current value; wrap is sticky until clear.
  always_comb begin
    wrap_d = wrap_q;
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (RSel[i]) begin
        case (FunSel)
          3'd0: begin
            regs_d[i] = '0;
            wrap_d[i] = 1'b0;
          end
          3'd1: regs_d[i] = I;
          3'd2: begin
            if (regs_q[i] == '0) begin
              wrap_d[i] = 1'b1;
              regs_d[i] = (SAT != 0) ? '0 : ONES;
            end else begin
              regs_d[i] = regs_q[i] - WIDTH'(1);
            end
          end
          3'd3: begin
            if (regs_q[i] == ONES) begin
              wrap_d[i] = 1'b1;
              regs_d[i] = (SAT != 0) ? ONES : '0;
            end else begin
              regs_d[i] = regs_q[i] + WIDTH'(1);
            end
          end
          3'd4: regs_d[i][HALF-1:0] = I[HALF-1:0];
          3'd5: regs_d[i][WIDTH-1:HALF] = I[HALF-1:0];
          3'd6: begin
            wrap_d[i] = wrap_q[i] | regs_q[i][WIDTH-1];
            regs_d[i] = {regs_q[i][WIDTH-2:0], 1'b0};
          end
          default: begin
            wrap_d[i] = wrap_q[i] | regs_q[i][0];
            regs_d[i] = {1'b0, regs_q[i][WIDTH-1:1]};
          end
        endcase
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      wrap_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      wrap_q <= wrap_d;
    end
  end

  // Indices with no backing register (non-power-of-2 NREG) read as zero.
  always_comb begin
    OutA = '0;
    OutB = '0;
    for (int i = 0; i < NREG; i++) begin
      if (OutASel == SW'(i)) OutA = regs_q[i];
      if (OutBSel == SW'(i)) OutB = regs_q[i];
    end
  end

  assign Wrap = wrap_q;

endmodule

// File: tb/tb_regbank_n.sv
// Bench for regbank_n: three configurations (8-bit wrap, 16-bit saturate, 6-register)
// driven in lockstep and compared against an integer-arithmetic reference model.
module tb_regbank_n;

  logic        Clock;
  logic        Reset;
  logic [2:0]  fs   [3];
  logic [15:0] din  [3];
  logic [5:0]  rsel [3];
  logic [2:0]  asel [3];
  logic [2:0]  bsel [3];

  logic [7:0]  oa0, ob0, oa2, ob2;
  logic [15:0] oa1, ob1;
  logic [3:0]  w0, w1;
  logic [5:0]  w2;

  int n_checks = 0;
  int n_fail   = 0;

  // Configuration of each instance, mirrored in the model.
  int wd  [3] = '{8, 16, 8};
  int nr  [3] = '{4, 4, 6};
  int sat [3] = '{0, 1, 0};
  int nsel[3] = '{4, 4, 8};

  int mreg  [3][6];
  bit mwrap [3][6];

  regbank_n #(.WIDTH(8), .NREG(4), .SAT(0)) u0 (
    .Clock(Clock), .Reset(Reset), .I(din[0][7:0]), .FunSel(fs[0]), .RSel(rsel[0][3:0]),
    .OutASel(asel[0][1:0]), .OutBSel(bsel[0][1:0]), .OutA(oa0), .OutB(ob0), .Wrap(w0)
  );
  regbank_n #(.WIDTH(16), .NREG(4), .SAT(1)) u1 (
    .Clock(Clock), .Reset(Reset), .I(din[1]), .FunSel(fs[1]), .RSel(rsel[1][3:0]),
    .OutASel(asel[1][1:0]), .OutBSel(bsel[1][1:0]), .OutA(oa1), .OutB(ob1), .Wrap(w1)
  );
  regbank_n #(.WIDTH(8), .NREG(6), .SAT(0)) u2 (
    .Clock(Clock), .Reset(Reset), .I(din[2][7:0]), .FunSel(fs[2]), .RSel(rsel[2]),
    .OutASel(asel[2]), .OutBSel(bsel[2]), .OutA(oa2), .OutB(ob2), .Wrap(w2)
  );

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_a(input int k);
    case (k)
      0: return {24'b0, oa0};
      1: return {16'b0, oa1};
      default: return {24'b0, oa2};
    endcase
  endfunction

  function automatic logic [31:0] dut_b(input int k);
    case (k)
      0: return {24'b0, ob0};
      1: return {16'b0, ob1};
      default: return {24'b0, ob2};
    endcase
  endfunction

  function automatic logic [31:0] dut_w(input int k);
    case (k)
      0: return {28'b0, w0};
      1: return {28'b0, w1};
      default: return {26'b0, w2};
    endcase
  endfunction

  function automatic int m_read(input int k, input int s);
    return (s < nr[k]) ? mreg[k][s] : 0;
  endfunction

  function automatic logic [31:0] m_wrap(input int k);
    logic [31:0] w = '0;
    for (int r = 0; r < nr[k]; r++) w[r] = mwrap[k][r];
    return w;
  endfunction

  function automatic void m_clear();
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 6; r++) begin
        mreg[k][r]  = 0;
        mwrap[k][r] = 1'b0;
      end
  endfunction

  // Reference behaviour stated as unsigned integer arithmetic on the register value.
  function automatic void m_step(input int k);
    int mx = (1 << wd[k]) - 1;
    int h  = wd[k] / 2;
    int hm = (1 << h) - 1;
    int d  = int'(din[k]) & mx;
    for (int r = 0; r < nr[k]; r++) begin
      if (rsel[k][r]) begin
        int v = mreg[k][r];
        case (fs[k])
          3'd0: begin v = 0; mwrap[k][r] = 1'b0; end
          3'd1: v = d;
          3'd2: if (v == 0) begin mwrap[k][r] = 1'b1; v = sat[k] ? 0 : mx; end else v = v - 1;
          3'd3: if (v == mx) begin mwrap[k][r] = 1'b1; v = sat[k] ? mx : 0; end else v = v + 1;
          3'd4: v = (v & ~hm) | (d & hm);
          3'd5: v = (v & hm) | ((d & hm) << h);
          3'd6: begin if (v > (mx >> 1)) mwrap[k][r] = 1'b1; v = (v * 2) & mx; end
          default: begin if (v % 2 == 1) mwrap[k][r] = 1'b1; v = v / 2; end
        endcase
        mreg[k][r] = v;
      end
    end
  endfunction

  // Sweeps every read index on both ports of every instance; ~8 time units.
  task automatic check_all();
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < 3; k++) begin
        asel[k] = 3'(s % nsel[k]);
        bsel[k] = 3'((7 - s) % nsel[k]);
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        check($sformatf("outa_k%0d_s%0d", k, s % nsel[k]), dut_a(k), 32'(m_read(k, s % nsel[k])));
        check($sformatf("outb_k%0d_s%0d", k, (7 - s) % nsel[k]), dut_b(k), 32'(m_read(k, (7 - s) % nsel[k])));
      end
    end
    for (int k = 0; k < 3; k++) check($sformatf("wrap_k%0d", k), dut_w(k), m_wrap(k));
  endtask

  task automatic drive(input int k, input int f, input int d, input int rs);
    fs[k]   = 3'(f);
    din[k]  = 16'(d);
    rsel[k] = 6'(rs);
  endtask

  // One clock edge: model follows the sampled inputs, selects drop, then full readback.
  task automatic tick();
    @(posedge Clock);
    if (Reset) m_clear();
    else for (int k = 0; k < 3; k++) m_step(k);
    #1;
    for (int k = 0; k < 3; k++) rsel[k] = '0;
    check_all();
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    #1;
    m_clear();
    check_all();
    Reset = 1'b0;
  endtask

  task automatic peek(input int k, input int sa, input int sb);
    asel[k] = 3'(sa);
    bsel[k] = 3'(sb);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(k, 0, 0, 0);
      asel[k] = '0;
      bsel[k] = '0;
    end
    m_clear();
    #3;
    check_all();
    @(negedge Clock);
    Reset = 1'b0;

    // Reset between edges clears everything before the next edge.
    for (int k = 0; k < 3; k++) drive(k, 1, 'hA5, 'h3F);
    tick();
    pulse_reset();
    check("rst_wrap0", dut_w(0), 32'h0);

    // Reset held across an edge discards the pending operation.
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) drive(k, 1, 'h5A, 'h3F);
    tick();
    Reset = 1'b0;

    // Load two registers, others stay zero.
    drive(0, 1, 'h3C, 'b0101);
    tick();
    peek(0, 0, 2);
    check("ld_outa", dut_a(0), 32'h3C);
    check("ld_outb", dut_b(0), 32'h3C);

    // Modulo wrap on instance 0, register 0.
    drive(0, 1, 'hFF, 1); tick();
    drive(0, 3, 0, 1);    tick();
    peek(0, 0, 0);
    check("inc_wrap_val", dut_a(0), 32'h00);
    check("inc_wrap_flag", dut_w(0) & 32'h1, 32'h1);
    drive(0, 2, 0, 1);    tick();
    peek(0, 0, 0);
    check("dec_wrap_val", dut_a(0), 32'hFF);
    drive(0, 0, 0, 1);    tick();
    check("clr_flag", dut_w(0) & 32'h1, 32'h0);

    // Saturation on the 16-bit instance, register 1.
    drive(1, 0, 0, 2);       tick();
    drive(1, 2, 0, 2);       tick();
    drive(1, 2, 0, 2);       tick();
    peek(1, 1, 1);
    check("sat_dec_val", dut_a(1), 32'h0000);
    check("sat_dec_flag", dut_w(1) & 32'h2, 32'h2);
    drive(1, 1, 'hFFFF, 2);  tick();
    drive(1, 3, 0, 2);       tick();
    peek(1, 1, 1);
    check("sat_inc_val", dut_a(1), 32'hFFFF);

    // Half loads and shifts on register 2.
    drive(0, 0, 0, 4);    tick();
    drive(0, 4, 'h07, 4); tick();
    drive(0, 5, 'h0A, 4); tick();
    peek(0, 2, 2);
    check("ldh_val", dut_a(0), 32'hA7);
    drive(0, 6, 0, 4);    tick();
    peek(0, 2, 2);
    check("shl_val", dut_a(0), 32'h4E);
    check("shl_flag", dut_w(0) & 32'h4, 32'h4);
    drive(0, 7, 0, 4);    tick();
    peek(0, 2, 2);
    check("shr_val", dut_a(0), 32'h27);

    // Unselected hold on the 6-register instance; out-of-range index reads zero.
    drive(2, 1, 'h81, 'h3F); tick();
    for (int c = 0; c < 3; c++) begin
      drive(2, 3, 0, 0);
      tick();
    end
    peek(2, 7, 6);
    check("oor_outa", dut_a(2), 32'h0);
    check("oor_outb", dut_b(2), 32'h0);

    // Randomised operations on all instances.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 3; k++) begin
        int d;
        int f;
        int rs;
        d  = int'($urandom_range(0, 65535));
        if ($urandom_range(0, 5) == 0) d = (d > 32767) ? 'hFFFF : 0;
        f  = int'($urandom_range(0, 7));
        rs = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(0, 63));
        drive(k, f, d, rs);
      end
      if ($urandom_range(0, 60) == 0) begin
        @(negedge Clock);
        pulse_reset();
      end else begin
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_n.md
# regbank_n

Parametrised general-purpose register bank: NREG registers of WIDTH bits, each with the full FunSel operation set (clear, load, decrement, increment, half-loads, shifts), two independent combinational read ports and per-register sticky wrap/saturate flags. It is the next-generation replacement for the fixed 8-bit single register and 4-register file in the ALU system datapath. It sits between MuxA (write data) and the ALU operand muxes (OutA/OutB).

## Interface
- WIDTH, 8: register width in bits; even, >= 2.
- NREG, 4: number of registers; >= 2.
- SAT, 0: 0 = inc/dec wrap modulo 2^WIDTH; 1 = inc/dec saturate at all-ones/zero.
- SW = max(1, $clog2(NREG)): derived select width (localparam).

- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- I  in  WIDTH  write data.
- FunSel  in  3  operation applied to every selected register (see Operation).
- RSel  in  NREG  one-hot-or-more register select; bit i enables register i; all-zero = hold all.
- OutASel  in  SW  read-port A register index.
- OutBSel  in  SW  read-port B register index.
- OutA  out  WIDTH  contents of register OutASel.
- OutB  out  WIDTH  contents of register OutBSel.
- Wrap  out  NREG  per-register sticky wrap/saturate flag.

## Operation
- FunSel encoding, applied to each register i with RSel[i]=1 on the clock edge:
  - 0 clear: R=0, Wrap[i]=0.
  - 1 load: R=I.
  - 2 decrement: R=R-1; at R=0: SAT=0 -> all-ones, SAT=1 -> stays 0; either case sets Wrap[i].
  - 3 increment: R=R+1; at R=all-ones: SAT=0 -> 0, SAT=1 -> stays all-ones; either case sets Wrap[i].
  - 4 load low: R[WIDTH/2-1:0]=I[WIDTH/2-1:0], upper half unchanged.
  - 5 load high: R[WIDTH-1:WIDTH/2]=I[WIDTH/2-1:0], lower half unchanged.
  - 6 shift left logical by 1, LSB=0; Wrap[i] set if shifted-out MSB was 1.
  - 7 shift right logical by 1, MSB=0; Wrap[i] set if shifted-out LSB was 1.
- Wrap[i] only changes when register i is selected: set by events above, cleared only by FunSel 0; otherwise holds (sticky).
- Registers with RSel[i]=0 hold value and flag regardless of FunSel.
- Multiple RSel bits: same op applied independently to each selected register, each using its own current value.
- Read ports purely combinational from register state; OutASel=OutBSel allowed (both show same register).
- Select index >= NREG (non-power-of-2 NREG): port outputs 0.
- All arithmetic is WIDTH-bit unsigned; no carry output beyond Wrap.

## Timing
- Reset asserted: all registers and Wrap cleared to 0 immediately (async), OutA/OutB = 0 combinationally; holds while Reset=1, ignoring FunSel/RSel.
- Reset deasserted: first operation takes effect on the next rising Clock edge.
- Reset asserted mid-sequence: any pending operation is discarded; state 0 immediately.
- Write latency 1 cycle: result of edge n visible on OutA/OutB after edge n (same cycle the next inputs apply).
- No read-during-write bypass: in the cycle before the edge, ports show pre-operation value.
- Wrap updates on the same edge as the register write that caused it.
- Inputs sampled only at rising Clock; no multi-cycle operations, no handshake.

## Test plan
- Reset: load 8'hA5 into all 4 regs, assert Reset between edges -> OutA=OutB=0 and Wrap=4'b0000 before next edge.
- Load/read: RSel=4'b0101, FunSel=1, I=8'h3C; then OutASel=0, OutBSel=2 -> OutA=OutB=8'h3C; regs 1,3 read 0.
- Wrap mode (SAT=0): R0=8'hFF, FunSel=3 -> R0=8'h00, Wrap[0]=1; then FunSel=2 -> R0=8'hFF, Wrap[0] stays 1; FunSel=0 -> R0=0, Wrap[0]=0.
- Saturate mode (SAT=1, WIDTH=16): R1=16'h0000, FunSel=2 twice -> R1=16'h0000, Wrap[1]=1; R1=16'hFFFF, FunSel=3 -> 16'hFFFF.
- Half loads and shifts: R2=0; FunSel=4, I=8'h07 -> 8'h07; FunSel=5, I=8'h0A -> 8'hA7; FunSel=6 -> 8'h4E, Wrap[2]=1; FunSel=7 -> 8'h27, Wrap[2] stays 1.
- Unselected hold and NREG=6: RSel=0 for 3 cycles with FunSel=3 -> no change; OutASel=7 -> OutA=0.
